// File: rtl/mul_hilo_seq_pkg.sv
// Shared constants and state encoding for the multiply sequencer and its
// HI/LO correction stage.
package mul_hilo_seq_pkg;
   localparam int HILO_W      = 32;
   localparam int DEF_MUL_LAT = 2;
   localparam int CNT_W       = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;
endpackage

// File: rtl/mul_hilo_seq_hilo_correct.sv
// Turns the signed product's upper word into the unsigned one when requested:
// each operand with its top bit set contributes the other operand to HI.
module hilo_correct
   import mul_hilo_seq_pkg::*;
(
   input  logic [HILO_W-1:0] i_mul_hi,
   input  logic [HILO_W-1:0] i_mul_a,
   input  logic [HILO_W-1:0] i_mul_b,
   input  logic              i_unsigned,
   output logic [HILO_W-1:0] o_hi
);
   logic [HILO_W-1:0] w_add_a;
   logic [HILO_W-1:0] w_add_b;

   assign w_add_a = (i_unsigned && i_mul_a[HILO_W-1]) ? i_mul_b : '0;
   assign w_add_b = (i_unsigned && i_mul_b[HILO_W-1]) ? i_mul_a : '0;
   assign o_hi    = i_mul_hi + w_add_a + w_add_b;
endmodule

// File: rtl/mul_hilo_seq.sv
// Multicycle sequencer around an external combinational 32x32 signed
// multiplier, plus the architectural HI/LO pair with direct bus writes.
module mul_hilo_seq
   import mul_hilo_seq_pkg::*;
#(
   parameter int MUL_LAT = DEF_MUL_LAT
)(
   input  logic              clk,
   input  logic              clr,
   input  logic              start,
   input  logic              is_unsigned,
   input  logic [HILO_W-1:0] op_a,
   input  logic [HILO_W-1:0] op_b,
   output logic [HILO_W-1:0] mul_a,
   output logic [HILO_W-1:0] mul_b,
   input  logic [HILO_W-1:0] mul_hi,
   input  logic [HILO_W-1:0] mul_lo,
   input  logic              hi_wr,
   input  logic              lo_wr,
   input  logic [HILO_W-1:0] bus_in,
   output logic              busy,
   output logic              done,
   output logic [HILO_W-1:0] hi_q,
   output logic [HILO_W-1:0] lo_q
);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 1);

   state_t            r_state;
   state_t            w_state_next;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_next;
   logic [HILO_W-1:0] r_mul_a;
   logic [HILO_W-1:0] r_mul_b;
   logic              r_uns;
   logic [HILO_W-1:0] r_hi;
   logic [HILO_W-1:0] r_lo;
   logic              r_busy;
   logic              r_done;
   logic              w_busy_next;
   logic              w_done_next;
   logic              w_accept;
   logic              w_write;
   logic              w_bus_ok;
   logic [HILO_W-1:0] w_hi_corr;

   hilo_correct u_correct (
      .i_mul_hi   (mul_hi),
      .i_mul_a    (r_mul_a),
      .i_mul_b    (r_mul_b),
      .i_unsigned (r_uns),
      .o_hi       (w_hi_corr)
   );

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_accept     = 1'b0;
      w_write      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_accept     = 1'b1;
               w_cnt_next   = CNT_LOAD;
               w_state_next = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (r_cnt == '0) begin
               w_state_next = ST_WRITE;
            end else begin
               w_cnt_next = r_cnt - 1'b1;
            end
         end
         ST_WRITE: begin
            w_write      = 1'b1;
            w_state_next = ST_DONE;
         end
         ST_DONE: begin
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
      // Moore flags are computed from the next state and registered.
      w_busy_next = (w_state_next == ST_WAIT) || (w_state_next == ST_WRITE);
      w_done_next = (w_state_next == ST_DONE);
      w_bus_ok    = (r_state == ST_IDLE) || (r_state == ST_DONE);
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_mul_a <= '0;
         r_mul_b <= '0;
         r_uns   <= 1'b0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         r_busy  <= w_busy_next;
         r_done  <= w_done_next;
         if (w_accept) begin
            r_mul_a <= op_a;
            r_mul_b <= op_b;
            r_uns   <= is_unsigned;
         end
         // Bus moves are locked out while a product is in flight.
         if (w_write) begin
            r_hi <= w_hi_corr;
            r_lo <= mul_lo;
         end else begin
            if (hi_wr && w_bus_ok) r_hi <= bus_in;
            if (lo_wr && w_bus_ok) r_lo <= bus_in;
         end
      end
   end

   assign mul_a = r_mul_a;
   assign mul_b = r_mul_b;
   assign busy  = r_busy;
   assign done  = r_done;
   assign hi_q  = r_hi;
   assign lo_q  = r_lo;
endmodule

// File: doc/mul_hilo_seq.md
Name: mul_hilo_seq

Overview:
- Multicycle sequencer and HI/LO register pair around the combinational 32x32 signed Booth multiplier.
- Upstream side: accepts a multiply request from the control unit, registers the operands and drives them to the multiplier.
- Waits a configurable settle time, applies the unsigned correction if requested, then writes the 64-bit product into the architectural HI/LO registers.
- HI/LO are also directly writable from the datapath bus (mthi/mtlo-style moves).

Parameters:
- MUL_LAT, 2, cycles allowed for the multiplier's combinational path (multicycle constraint); legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge
- clr  in  1  asynchronous active-high reset
- start  in  1  multiply request, sampled only in IDLE
- is_unsigned  in  1  1 = unsigned multiply, 0 = signed; sampled with start
- op_a  in  32  multiplicand, sampled with start
- op_b  in  32  multiplier, sampled with start
- mul_a  out  32  registered multiplicand to the multiplier
- mul_b  out  32  registered multiplier to the multiplier
- mul_hi  in  32  signed product bits 63:32 from the multiplier
- mul_lo  in  32  signed product bits 31:0 from the multiplier
- hi_wr  in  1  direct write of bus_in into HI
- lo_wr  in  1  direct write of bus_in into LO
- bus_in  in  32  datapath bus data
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse, result valid in HI/LO
- hi_q  out  32  HI register
- lo_q  out  32  LO register

Behaviour:
- Reset (clr high, asynchronous): state=IDLE, counter=0, mul_a=mul_b=0, unsigned flag=0, hi_q=lo_q=0, busy=0, done=0.
- Reset mid-operation aborts the operation; no HI/LO write and no done pulse occur.
- States:
  - IDLE: on start, capture op_a/op_b into mul_a/mul_b, capture is_unsigned, load counter=MUL_LAT-1, go to WAIT. busy=0 in IDLE.
  - WAIT: busy=1. If counter==0 go to WRITE; otherwise decrement.
  - WRITE: busy=1. Load hi_q/lo_q with the corrected product, go to DONE.
  - DONE: busy=0, done=1 for exactly this cycle; hi_q/lo_q already hold the result. Next state IDLE. A start in DONE is ignored.
- Latency: start sampled at edge E0; HI/LO written at edge E0+MUL_LAT+1; done high during the following cycle. Back-to-back throughput is one op per MUL_LAT+3 cycles.
- Arithmetic:
  - lo_q = mul_lo.
  - Signed: hi_q = mul_hi.
  - Unsigned: hi_q = mul_hi + (mul_a[31] ? mul_b : 0) + (mul_b[31] ? mul_a : 0), modulo 2^32. This is the two's-complement to unsigned correction.
- Operand stability: mul_a/mul_b hold their values from capture until the next accepted start. op_a/op_b changing after capture has no effect.
- Direct writes:
  - hi_wr/lo_wr take effect at the clock edge in IDLE or DONE.
  - Ignored while in WAIT or WRITE, so an in-flight result is never corrupted.
  - hi_wr and lo_wr in the same cycle both apply.
- Simultaneous events:
  - start together with hi_wr in IDLE: the bus write applies, and the op starts and later overwrites HI.
  - start while busy: ignored; no queuing.
- done never coincides with busy. done and busy are registered (Moore) outputs.

Decomposition:
- Shared package holds:
  - State encoding constants: IDLE=2'd0, WAIT=2'd1, WRITE=2'd2, DONE=2'd3.
  - Default MUL_LAT.
  - HI/LO width constant 32.
- One natural sub-module: hilo_correct. It is combinational and computes the unsigned-corrected HI from mul_hi, mul_a, mul_b and the unsigned flag.
- The FSM, counter and registers stay in the top module.
- The bench instantiates the real multiplier between mul_a/mul_b and mul_hi/mul_lo.

Test Plan:
- Reset check: assert clr mid-WAIT after start with op_a=5, op_b=6 -> busy=0, hi_q=lo_q=0 immediately; no done pulse follows.
- Signed multiply, op_a=7, op_b=32'hFFFFFFFD, is_unsigned=0, MUL_LAT=2 -> at E0+3 hi_q=32'hFFFFFFFF, lo_q=32'hFFFFFFEB; done high for exactly the next cycle.
- Unsigned multiply, op_a=32'hFFFFFFFF, op_b=2, is_unsigned=1 -> hi_q=1, lo_q=32'hFFFFFFFE. The same operands signed give hi_q=32'hFFFFFFFF.
- Unsigned max: op_a=op_b=32'hFFFFFFFF, is_unsigned=1 -> hi_q=32'hFFFFFFFE, lo_q=1.
- Bus write interaction:
  - hi_wr with bus_in=32'hDEADBEEF during WAIT -> ignored; hi_q ends as the product.
  - hi_wr in IDLE -> hi_q=32'hDEADBEEF the next cycle.
  - start plus lo_wr in the same IDLE cycle -> lo_q=bus_in first, then the product.
- Start while busy: second start with op_a=9 pulsed during WAIT -> ignored; mul_a unchanged, only one done pulse.
- Parameter sweep: MUL_LAT=1 and MUL_LAT=15 -> product written at E0+MUL_LAT+1.
